// File: rtl/arbitration_sub_module.sv
// Bus-isolation front end between one CPU core and the shared data and
// instruction buses. Each channel (D, I) requests its bus from the arbiter and
// forwards core signals only while it owns the bus and the grant is held.
// Build option: define ARB_TRISTATE_EN to drive released bus outputs to Z
// (shared wired bus); leave undefined to drive them to 0 (OR-combined bus).

// Channel handshake FSM, one instance per bus channel.
//   state     | meaning
//   S_IDLE    | no request, bus released
//   S_REQ     | request raised, waiting for grant, bus released
//   S_OWN     | granted, core signals forwarded while grant holds
//   S_RELEASE | request withdrawn, waiting for arbiter to drop grant
module arbitration_sub_module_chan (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic grant,
  output logic rq,
  output logic own
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_RELEASE} state_t;
  state_t state, state_nx;

  // State register; reset returns the channel to IDLE at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and outputs; a lost grant in OWN releases the bus in the same cycle.
  always_comb begin
    state_nx = state;
    rq       = 1'b0;
    own      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) state_nx = S_REQ;
      end
      S_REQ: begin
        rq = 1'b1;
        if (!req)       state_nx = S_RELEASE;
        else if (grant) state_nx = S_OWN;
      end
      S_OWN: begin
        rq  = 1'b1;
        own = grant;
        if (!req)        state_nx = S_RELEASE;
        else if (!grant) state_nx = S_REQ;
      end
      S_RELEASE: begin
        if (!grant) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

module arbitration_sub_module #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int WSTB_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              P_DataMem_Read,
  input  logic [WSTB_W-1:0] P_DataMem_Write,
  input  logic [ADDR_W-1:0] P_DataMem_Address,
  input  logic [DATA_W-1:0] P_DataMem_Out,
  output logic [DATA_W-1:0] P_DataMem_In,
  output logic              P_DataMem_Ready,
  output logic              Bus_DataMem_Read,
  output logic [WSTB_W-1:0] Bus_DataMem_Write,
  output logic [ADDR_W-1:0] Bus_DataMem_Address,
  output logic [DATA_W-1:0] Bus_DataMem_Out,
  input  logic [DATA_W-1:0] Bus_DataMem_In,
  input  logic              Bus_DataMem_Ready,
  output logic              D_Bus_RQ,
  input  logic              D_Bus_GRANT,
  input  logic [ADDR_W-1:0] P_InstMem_Address,
  input  logic              P_InstMem_Read,
  output logic [DATA_W-1:0] P_InstMem_In,
  output logic              P_InstMem_Ready,
  output logic [ADDR_W-1:0] Bus_InstMem_Address,
  output logic              Bus_InstMem_Read,
  input  logic [DATA_W-1:0] Bus_InstMem_In,
  input  logic              Bus_InstMem_Ready,
  output logic              I_Bus_RQ,
  input  logic              I_Bus_GRANT
);
`ifdef ARB_TRISTATE_EN
  localparam logic REL_BIT = 1'bz;
`else
  localparam logic REL_BIT = 1'b0;
`endif

  logic d_req, d_own, i_req, i_own;

  // Read and write may both be set on D; both are forwarded, no check made.
  assign d_req = P_DataMem_Read | (|P_DataMem_Write);
  assign i_req = P_InstMem_Read;

  arbitration_sub_module_chan u_d_chan (
    .clk   (clk),
    .reset (reset),
    .req   (d_req),
    .grant (D_Bus_GRANT),
    .rq    (D_Bus_RQ),
    .own   (d_own)
  );

  arbitration_sub_module_chan u_i_chan (
    .clk   (clk),
    .reset (reset),
    .req   (i_req),
    .grant (I_Bus_GRANT),
    .rq    (I_Bus_RQ),
    .own   (i_own)
  );

  assign Bus_DataMem_Read    = d_own ? P_DataMem_Read    : REL_BIT;
  assign Bus_DataMem_Write   = d_own ? P_DataMem_Write   : {WSTB_W{REL_BIT}};
  assign Bus_DataMem_Address = d_own ? P_DataMem_Address : {ADDR_W{REL_BIT}};
  assign Bus_DataMem_Out     = d_own ? P_DataMem_Out     : {DATA_W{REL_BIT}};
  assign P_DataMem_In        = d_own ? Bus_DataMem_In    : '0;
  assign P_DataMem_Ready     = d_own & Bus_DataMem_Ready;

  assign Bus_InstMem_Address = i_own ? P_InstMem_Address : {ADDR_W{REL_BIT}};
  assign Bus_InstMem_Read    = i_own ? P_InstMem_Read    : REL_BIT;
  assign P_InstMem_In        = i_own ? Bus_InstMem_In    : '0;
  assign P_InstMem_Ready     = i_own & Bus_InstMem_Ready;
endmodule

// File: tb/tb_arbitration_sub_module.sv
module tb_arbitration_sub_module;
  logic        clk;
  logic        reset;
  logic        P_DataMem_Read;
  logic [3:0]  P_DataMem_Write;
  logic [29:0] P_DataMem_Address;
  logic [31:0] P_DataMem_Out;
  logic [31:0] P_DataMem_In;
  logic        P_DataMem_Ready;
  logic        Bus_DataMem_Read;
  logic [3:0]  Bus_DataMem_Write;
  logic [29:0] Bus_DataMem_Address;
  logic [31:0] Bus_DataMem_Out;
  logic [31:0] Bus_DataMem_In;
  logic        Bus_DataMem_Ready;
  logic        D_Bus_RQ;
  logic        D_Bus_GRANT;
  logic [29:0] P_InstMem_Address;
  logic        P_InstMem_Read;
  logic [31:0] P_InstMem_In;
  logic        P_InstMem_Ready;
  logic [29:0] Bus_InstMem_Address;
  logic        Bus_InstMem_Read;
  logic [31:0] Bus_InstMem_In;
  logic        Bus_InstMem_Ready;
  logic        I_Bus_RQ;
  logic        I_Bus_GRANT;

  int n_assert = 0;
  int n_fail   = 0;

  logic        rel1;
  logic [3:0]  rel4;
  logic [29:0] rel30;
  logic [31:0] rel32;

  arbitration_sub_module dut (
    .clk                 (clk),
    .reset               (reset),
    .P_DataMem_Read      (P_DataMem_Read),
    .P_DataMem_Write     (P_DataMem_Write),
    .P_DataMem_Address   (P_DataMem_Address),
    .P_DataMem_Out       (P_DataMem_Out),
    .P_DataMem_In        (P_DataMem_In),
    .P_DataMem_Ready     (P_DataMem_Ready),
    .Bus_DataMem_Read    (Bus_DataMem_Read),
    .Bus_DataMem_Write   (Bus_DataMem_Write),
    .Bus_DataMem_Address (Bus_DataMem_Address),
    .Bus_DataMem_Out     (Bus_DataMem_Out),
    .Bus_DataMem_In      (Bus_DataMem_In),
    .Bus_DataMem_Ready   (Bus_DataMem_Ready),
    .D_Bus_RQ            (D_Bus_RQ),
    .D_Bus_GRANT         (D_Bus_GRANT),
    .P_InstMem_Address   (P_InstMem_Address),
    .P_InstMem_Read      (P_InstMem_Read),
    .P_InstMem_In        (P_InstMem_In),
    .P_InstMem_Ready     (P_InstMem_Ready),
    .Bus_InstMem_Address (Bus_InstMem_Address),
    .Bus_InstMem_Read    (Bus_InstMem_Read),
    .Bus_InstMem_In      (Bus_InstMem_In),
    .Bus_InstMem_Ready   (Bus_InstMem_Ready),
    .I_Bus_RQ            (I_Bus_RQ),
    .I_Bus_GRANT         (I_Bus_GRANT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d_released(input string tag);
    chk({tag, ".d_read"},  {31'd0, Bus_DataMem_Read},   {31'd0, rel1});
    chk({tag, ".d_write"}, {28'd0, Bus_DataMem_Write},  {28'd0, rel4});
    chk({tag, ".d_addr"},  {2'd0, Bus_DataMem_Address}, {2'd0, rel30});
    chk({tag, ".d_out"},   Bus_DataMem_Out,             rel32);
    chk({tag, ".d_pin"},   P_DataMem_In,                32'd0);
    chk({tag, ".d_prdy"},  {31'd0, P_DataMem_Ready},    32'd0);
  endtask

  task automatic chk_i_released(input string tag);
    chk({tag, ".i_addr"}, {2'd0, Bus_InstMem_Address}, {2'd0, rel30});
    chk({tag, ".i_read"}, {31'd0, Bus_InstMem_Read},   {31'd0, rel1});
    chk({tag, ".i_pin"},  P_InstMem_In,                32'd0);
    chk({tag, ".i_prdy"}, {31'd0, P_InstMem_Ready},    32'd0);
  endtask

  initial begin
`ifdef ARB_TRISTATE_EN
    rel1 = 1'bz; rel4 = 'z; rel30 = 'z; rel32 = 'z;
`else
    rel1 = 1'b0; rel4 = '0; rel30 = '0; rel32 = '0;
`endif
    reset = 1'b1;
    P_DataMem_Read = 1'b0; P_DataMem_Write = 4'd0; P_DataMem_Address = 30'd0;
    P_DataMem_Out = 32'd0; Bus_DataMem_In = 32'd0; Bus_DataMem_Ready = 1'b0;
    D_Bus_GRANT = 1'b0;
    P_InstMem_Address = 30'd0; P_InstMem_Read = 1'b0;
    Bus_InstMem_In = 32'd0; Bus_InstMem_Ready = 1'b0; I_Bus_GRANT = 1'b0;
    #100;
    reset = 1'b0;
    #1;

    // 1: idle after reset, with bus ready/data present that must be ignored
    Bus_DataMem_Ready = 1'b1; Bus_DataMem_In = 32'h1111_2222;
    Bus_InstMem_Ready = 1'b1; Bus_InstMem_In = 32'h3333_4444;
    #1;
    chk("t1.d_rq", {31'd0, D_Bus_RQ}, 32'd0);
    chk("t1.i_rq", {31'd0, I_Bus_RQ}, 32'd0);
    chk_d_released("t1");
    chk_i_released("t1");
    tick();
    chk("t1.d_rq_idle", {31'd0, D_Bus_RQ}, 32'd0);
    chk("t1.i_rq_idle", {31'd0, I_Bus_RQ}, 32'd0);

    // 2: I fetch request, grant withheld three cycles
    P_InstMem_Read = 1'b1; P_InstMem_Address = 30'd5;
    Bus_InstMem_In = 32'd9; Bus_InstMem_Ready = 1'b1;
    #1;
    chk("t2.i_rq_before_edge", {31'd0, I_Bus_RQ}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t2.i_rq_req", {31'd0, I_Bus_RQ}, 32'd1);
      chk_i_released("t2");
    end
    chk("t2.d_rq_quiet", {31'd0, D_Bus_RQ}, 32'd0);

    // 3: grant arrives; forwarding starts the following edge
    I_Bus_GRANT = 1'b1;
    #1;
    chk_i_released("t3.pre");
    tick();
    chk("t3.i_rq",      {31'd0, I_Bus_RQ},            32'd1);
    chk("t3.i_busaddr", {2'd0, Bus_InstMem_Address},  32'd5);
    chk("t3.i_busread", {31'd0, Bus_InstMem_Read},    32'd1);
    chk("t3.i_pin",     P_InstMem_In,                 32'd9);
    chk("t3.i_prdy",    {31'd0, P_InstMem_Ready},     32'd1);
    P_InstMem_Address = 30'd6; Bus_InstMem_In = 32'hCAFE_0001; Bus_InstMem_Ready = 1'b0;
    #1;
    chk("t3.i_busaddr_live", {2'd0, Bus_InstMem_Address}, 32'd6);
    chk("t3.i_pin_live",     P_InstMem_In,                32'hCAFE_0001);
    chk("t3.i_prdy_low",     {31'd0, P_InstMem_Ready},    32'd0);
    chk_d_released("t3");

    // 4: drop request; RELEASE holds until grant falls
    P_InstMem_Read = 1'b0; Bus_InstMem_Ready = 1'b1;
    #1;
    chk("t4.i_rq_same_cycle", {31'd0, I_Bus_RQ}, 32'd1);
    tick();
    chk("t4.i_rq_release", {31'd0, I_Bus_RQ}, 32'd0);
    chk_i_released("t4");
    P_InstMem_Read = 1'b1;
    tick();
    chk("t4.i_rq_hold_release", {31'd0, I_Bus_RQ}, 32'd0);
    chk_i_released("t4.hold");
    I_Bus_GRANT = 1'b0;
    tick();
    chk("t4.i_rq_idle", {31'd0, I_Bus_RQ}, 32'd0);
    tick();
    chk("t4.i_rq_rerequest", {31'd0, I_Bus_RQ}, 32'd1);
    P_InstMem_Read = 1'b0;
    I_Bus_GRANT = 1'b1;
    tick();
    chk("t4.i_drop_before_grant", {31'd0, I_Bus_RQ}, 32'd0);
    chk_i_released("t4.drop");
    I_Bus_GRANT = 1'b0;
    tick();
    chk("t4.i_rq_idle2", {31'd0, I_Bus_RQ}, 32'd0);

    // 5: D byte write, granted, then pre-empted
    P_DataMem_Write = 4'b0100; P_DataMem_Address = 30'd31; P_DataMem_Out = 32'd127;
    Bus_DataMem_In = 32'h0000_ABCD; Bus_DataMem_Ready = 1'b1;
    tick();
    chk("t5.d_rq_req", {31'd0, D_Bus_RQ}, 32'd1);
    chk_d_released("t5.req");
    D_Bus_GRANT = 1'b1;
    tick();
    chk("t5.d_rq",       {31'd0, D_Bus_RQ},            32'd1);
    chk("t5.d_buswrite", {28'd0, Bus_DataMem_Write},   32'h4);
    chk("t5.d_busaddr",  {2'd0, Bus_DataMem_Address},  32'd31);
    chk("t5.d_busout",   Bus_DataMem_Out,              32'd127);
    chk("t5.d_busread",  {31'd0, Bus_DataMem_Read},    32'd0);
    chk("t5.d_pin",      P_DataMem_In,                 32'h0000_ABCD);
    chk("t5.d_prdy",     {31'd0, P_DataMem_Ready},     32'd1);
    chk("t5.i_rq_indep", {31'd0, I_Bus_RQ},            32'd0);
    D_Bus_GRANT = 1'b0;
    #1;
    chk("t5.d_rq_preempt", {31'd0, D_Bus_RQ}, 32'd1);
    chk_d_released("t5.preempt");
    tick();
    chk("t5.d_rq_back_req", {31'd0, D_Bus_RQ}, 32'd1);
    chk_d_released("t5.backreq");
    P_DataMem_Read = 1'b1;
    D_Bus_GRANT = 1'b1;
    tick();
    chk("t5.d_rw_read",  {31'd0, Bus_DataMem_Read},  32'd1);
    chk("t5.d_rw_write", {28'd0, Bus_DataMem_Write}, 32'h4);

    // 6: async reset with D owning the bus and I requesting
    P_InstMem_Read = 1'b1;
    tick();
    chk("t6.i_rq_req",  {31'd0, I_Bus_RQ},         32'd1);
    chk("t6.d_own_pre", {31'd0, Bus_DataMem_Read}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6.d_rq", {31'd0, D_Bus_RQ}, 32'd0);
    chk("t6.i_rq", {31'd0, I_Bus_RQ}, 32'd0);
    chk_d_released("t6");
    chk_i_released("t6");
    tick();
    chk("t6.d_rq_held", {31'd0, D_Bus_RQ}, 32'd0);
    chk("t6.i_rq_held", {31'd0, I_Bus_RQ}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6.d_rq_after_rst", {31'd0, D_Bus_RQ}, 32'd0);
    tick();
    chk("t6.d_rq_rerequest", {31'd0, D_Bus_RQ}, 32'd1);
    chk("t6.i_rq_rerequest", {31'd0, I_Bus_RQ}, 32'd1);
    chk_d_released("t6.req");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
